// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states and PC constants.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC arithmetic: sequential PC+4 and branch/jump redirect target.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_brPcPlus4,
  input  logic [31:0] i_immExt,
  input  logic [25:0] i_jumpIndex,
  input  logic        i_branchTaken,
  input  logic        i_jump,
  output logic [31:0] o_pcPlus4,
  output logic        o_redirect,
  output logic [31:0] o_target
);

  logic [31:0] w_brOffset;
  logic [31:0] w_branchTarget;
  logic [31:0] w_jumpTarget;

  // Shifting the whole immediate left by two drops bits 31:30, matching the word offset.
  assign w_brOffset     = i_immExt << 2;
  assign w_branchTarget = i_brPcPlus4 + w_brOffset;
  assign w_jumpTarget   = {i_brPcPlus4[31:28], i_jumpIndex, 2'b00};

  assign o_pcPlus4  = i_pc + PC_STEP;
  assign o_redirect = i_jump | i_branchTaken;
  assign o_target   = i_jump ? w_jumpTarget : w_branchTarget;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake and
// holds each fetched word for decode, applying branch/jump redirects.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] br_pc_plus4,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_index,
  output logic [31:0] pc
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_addr;
  logic         r_req;
  logic         r_valid;
  logic [31:0]  r_instr;
  logic [31:0]  r_pcPlus4;

  logic [31:0]  w_pcPlus4;
  logic         w_redirect;
  logic [31:0]  w_target;

  next_pc_calc u_nextPc (
    .i_pc          (r_pc),
    .i_brPcPlus4   (br_pc_plus4),
    .i_immExt      (imm_ext),
    .i_jumpIndex   (jump_index),
    .i_branchTaken (branch_taken),
    .i_jump        (jump),
    .o_pcPlus4     (w_pcPlus4),
    .o_redirect    (w_redirect),
    .o_target      (w_target)
  );

  // r_addr mirrors r_pc everywhere except DRAIN, where it freezes the in-flight address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pcPlus4 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          if (w_redirect) begin
            r_pc   <= w_target;
            r_addr <= w_target;
          end
        end
        FETCH: begin
          if (w_redirect) begin
            r_pc <= w_target;
            if (imem_ready) r_addr  <= w_target;
            else            r_state <= DRAIN;
          end else if (imem_ready) begin
            r_instr   <= imem_rdata;
            r_pcPlus4 <= w_pcPlus4;
            r_valid   <= 1'b1;
            r_pc      <= w_pcPlus4;
            r_addr    <= w_pcPlus4;
            r_req     <= 1'b0;
            r_state   <= HOLD;
          end
        end
        DRAIN: begin
          if (w_redirect) r_pc <= w_target;
          if (imem_ready) begin
            r_state <= FETCH;
            r_addr  <= w_redirect ? w_target : r_pc;
          end
        end
        HOLD: begin
          // A redirect flushes the held instruction whether or not decode takes it.
          if (w_redirect || id_ready) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= FETCH;
            if (w_redirect) begin
              r_pc   <= w_target;
              r_addr <= w_target;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign if_valid    = r_valid;
  assign if_instr    = r_instr;
  assign if_pc_plus4 = r_pcPlus4;
  assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        branch_taken;
  logic        jump;
  logic [31:0] br_pc_plus4;
  logic [31:0] imm_ext;
  logic [25:0] jump_index;

  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic        a_valid, b_valid;
  logic [31:0] a_instr, b_instr;
  logic [31:0] a_pc4, b_pc4;
  logic [31:0] a_pc, b_pc;

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 1'b0;

  fetch_unit dutA (
    .clk(clk), .rst(rst), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_valid(a_valid),
    .if_instr(a_instr), .if_pc_plus4(a_pc4), .id_ready(id_ready),
    .branch_taken(branch_taken), .jump(jump), .br_pc_plus4(br_pc_plus4),
    .imm_ext(imm_ext), .jump_index(jump_index), .pc(a_pc)
  );

  fetch_unit #(.RESET_PC(WRAP_RESET_PC)) dutB (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_valid(b_valid),
    .if_instr(b_instr), .if_pc_plus4(b_pc4), .id_ready(id_ready),
    .branch_taken(branch_taken), .jump(jump), .br_pc_plus4(br_pc_plus4),
    .imm_ext(imm_ext), .jump_index(jump_index), .pc(b_pc)
  );

  always #5 clk = ~clk;

  // Model state: whether a request is in flight, whether its data is already doomed,
  // and what is currently being held for decode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        req;
    logic        stale;
    logic        valid;
    logic        started;
  } model_t;

  model_t mA, mB;

  function automatic model_t modelStep(model_t m, logic [31:0] resetPc);
    model_t      n;
    logic [31:0] tgt;
    logic        redirect;
    n        = m;
    redirect = jump | branch_taken;
    tgt      = jump ? {br_pc_plus4[31:28], jump_index, 2'b00}
                    : br_pc_plus4 + imm_ext * 32'd4;
    if (rst) begin
      n.pc = resetPc; n.addr = resetPc; n.instr = '0; n.pc4 = '0;
      n.req = 1'b0; n.stale = 1'b0; n.valid = 1'b0; n.started = 1'b0;
    end else if (!m.started) begin
      n.started = 1'b1;
      n.req     = 1'b1;
      if (redirect) n.pc = tgt;
      n.addr = n.pc;
    end else if (m.req) begin
      if (imem_ready) begin
        if (!m.stale && !redirect) begin
          n.valid = 1'b1; n.instr = imem_rdata;
          n.pc4 = m.addr + 32'd4; n.pc = m.addr + 32'd4;
          n.addr = n.pc; n.req = 1'b0;
        end else begin
          if (redirect) n.pc = tgt;
          n.addr  = n.pc;
          n.stale = 1'b0;
        end
      end else if (redirect) begin
        n.pc    = tgt;
        n.stale = 1'b1;
      end
    end else if (redirect || id_ready) begin
      n.valid = 1'b0;
      n.req   = 1'b1;
      if (redirect) n.pc = tgt;
      n.addr = n.pc;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mA = modelStep(mA, 32'h0000_0000);
    mB = modelStep(mB, WRAP_RESET_PC);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareDut(input string tag, input model_t m, input logic req,
                            input logic [31:0] addr, input logic valid,
                            input logic [31:0] instr, input logic [31:0] pc4,
                            input logic [31:0] pcv);
    checkOutput({tag, "_req"},   {31'b0, req},   {31'b0, m.req});
    checkOutput({tag, "_addr"},  addr,           m.addr);
    checkOutput({tag, "_valid"}, {31'b0, valid}, {31'b0, m.valid});
    checkOutput({tag, "_instr"}, instr,          m.instr);
    checkOutput({tag, "_pc4"},   pc4,            m.pc4);
    checkOutput({tag, "_pc"},    pcv,            m.pc);
  endtask

  always @(negedge clk) begin
    if (cmpOn) begin
      compareDut("mdlA", mA, a_req, a_addr, a_valid, a_instr, a_pc4, a_pc);
      compareDut("mdlB", mB, b_req, b_addr, b_valid, b_instr, b_pc4, b_pc);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic [31:0] rdata,
                               input logic idr, input logic br, input logic jmp,
                               input logic [31:0] bpc4, input logic [31:0] imm,
                               input logic [25:0] ji);
    rst = r; imem_ready = rdy; imem_rdata = rdata; id_ready = idr;
    branch_taken = br; jump = jmp; br_pc_plus4 = bpc4; imm_ext = imm; jump_index = ji;
  endtask

  initial begin
    logic [31:0] rnd;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0);
    tick();
    cmpOn = 1'b1;
    tick();
    checkOutput("rst_req",   {31'b0, a_req},   32'h0);
    checkOutput("rst_addr",  a_addr,           32'h0);
    checkOutput("rst_valid", {31'b0, a_valid}, 32'h0);
    checkOutput("rst_addrB", b_addr,           32'hFFFF_FFFC);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0);
    tick();
    checkOutput("fetch0_req",  {31'b0, a_req}, 32'h1);
    checkOutput("fetch0_addr", a_addr,         32'h0);

    imem_ready = 1'b1; imem_rdata = 32'h2008_000A;
    tick();
    checkOutput("hold0_valid", {31'b0, a_valid}, 32'h1);
    checkOutput("hold0_pc4",   a_pc4,            32'h4);
    checkOutput("hold0_instr", a_instr,          32'h2008_000A);
    checkOutput("wrap_pc4B",   b_pc4,            32'h0);

    imem_ready = 1'b0;
    tick();
    checkOutput("fetch1_addr",  a_addr, 32'h4);
    checkOutput("wrap_fetchB",  b_addr, 32'h0);
    imem_ready = 1'b1;
    tick();
    checkOutput("hold1_pc4", a_pc4, 32'h8);
    imem_ready = 1'b0;
    tick();
    checkOutput("fetch2_addr", a_addr, 32'h8);
    imem_ready = 1'b1;
    tick();
    checkOutput("hold2_pc4",   a_pc4,   32'hC);
    checkOutput("hold2_instr", a_instr, 32'h2008_000A);

    imem_ready = 1'b0; id_ready = 1'b0;
    repeat (5) begin
      tick();
      checkOutput("bp_valid", {31'b0, a_valid}, 32'h1);
      checkOutput("bp_pc4",   a_pc4,            32'hC);
      checkOutput("bp_req",   {31'b0, a_req},   32'h0);
    end
    id_ready = 1'b1;
    tick();
    checkOutput("bp_next_addr", a_addr, 32'hC);

    imem_ready = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFFF, 26'h0);
    tick();
    checkOutput("brneg_valid", {31'b0, a_valid}, 32'h0);
    checkOutput("brneg_addr",  a_addr,           32'h0FC);

    branch_taken = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; branch_taken = 1'b1; imm_ext = 32'h0000_000A;
    tick();
    checkOutput("brpos_addr",  a_addr,           32'h128);
    checkOutput("brpos_valid", {31'b0, a_valid}, 32'h0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1000_0010, 32'h0, 26'h040);
    tick();
    checkOutput("drain_addr", a_addr,         32'h128);
    checkOutput("drain_req",  {31'b0, a_req}, 32'h1);
    checkOutput("drain_pc",   a_pc,           32'h1000_0100);
    jump = 1'b0;
    repeat (2) tick();
    checkOutput("drain_hold_addr", a_addr, 32'h128);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    checkOutput("drain_done_addr",  a_addr,           32'h1000_0100);
    checkOutput("drain_done_valid", {31'b0, a_valid}, 32'h0);

    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h2000_0000,
                  32'h0000_0010, 26'h3);
    tick();
    checkOutput("both_addr",  a_addr,           32'h2000_000C);
    checkOutput("both_valid", {31'b0, a_valid}, 32'h0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 26'h80);
    tick();
    checkOutput("rdrain_pc",   a_pc,   32'h200);
    checkOutput("rdrain_addr", a_addr, 32'h2000_000C);
    jump = 1'b0; rst = 1'b1;
    tick();
    checkOutput("midrst_req",   {31'b0, a_req},   32'h0);
    checkOutput("midrst_pc",    a_pc,             32'h0);
    checkOutput("midrst_valid", {31'b0, a_valid}, 32'h0);
    checkOutput("midrst_pcB",   b_pc,             32'hFFFF_FFFC);

    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rnd          = $urandom;
      rst          = ($urandom_range(0, 299) == 0);
      imem_ready   = 1'($urandom_range(0, 1));
      imem_rdata   = $urandom;
      id_ready     = ($urandom_range(0, 9) < 6);
      jump         = ($urandom_range(0, 11) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      br_pc_plus4  = $urandom;
      imm_ext      = {{16{rnd[15]}}, rnd[15:0]};
      jump_index   = rnd[31:6];
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
